// File: rtl/dpram_stream_reader.sv
// Read-side burst controller for a dpram_128x8: issues sequential RAM reads and
// streams the returned words out through a 2-entry valid/ready buffer.
//
// state | meaning
// IDLE  | waiting for start; len=0 start only pulses done
// READ  | issuing reads while words remain and buffer credit allows
// DRAIN | all reads issued; waiting for the last word to be accepted
module dpram_stream_reader #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  RN,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic                  ren,
   output logic [ADDR_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]            state;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [LEN_WIDTH-1:0]  accepted;
   logic [LEN_WIDTH-1:0]  len_q;
   logic                  cap_pending;
   logic [DATA_WIDTH-1:0] buf_mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;
   logic [2:0]            occ;
   logic                  push;
   logic                  pop;
   logic                  credit_ok;
   logic                  issue;
   logic                  last_pop;

   assign out_valid = (count != 2'd0);
   assign out_data  = buf_mem[rd_ptr];
   assign pop       = out_valid & out_ready;
   assign push      = cap_pending;

   // A read occupies a credit from the cycle ren is high until its word leaves
   // the buffer, so the RAM strobe, the data-return cycle and the buffer share
   // two credits; a pop this cycle releases one for the next strobe.
   assign occ       = {1'b0, count} + {2'b0, cap_pending} + {2'b0, ren};
   assign credit_ok = (occ < 3'd2) || ((occ == 3'd2) && pop);
   assign issue     = (state == READ) && (remaining != '0) && credit_ok;
   assign last_pop  = pop && (accepted == (len_q - 1'b1));

   always_ff @(posedge clk or negedge RN) begin
      if (!RN) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         ren       <= 1'b0;
         raddr     <= '0;
         remaining <= '0;
         len_q     <= '0;
         accepted  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     state     <= READ;
                     busy      <= 1'b1;
                     ren       <= 1'b1;
                     raddr     <= start_addr;
                     remaining <= len - 1'b1;
                     len_q     <= len;
                     accepted  <= '0;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            READ: begin
               ren <= issue;
               if (issue) begin
                  raddr     <= raddr + 1'b1;
                  remaining <= remaining - 1'b1;
               end
               if (remaining == '0) state <= DRAIN;
               if (pop) accepted <= accepted + 1'b1;
            end
            DRAIN: begin
               ren <= 1'b0;
               if (pop) accepted <= accepted + 1'b1;
               if (last_pop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               ren   <= 1'b0;
            end
         endcase
      end
   end

   // RAM data lands on mem_data the cycle after ren and is pushed at that edge.
   always_ff @(posedge clk or negedge RN) begin
      if (!RN) begin
         cap_pending <= 1'b0;
         buf_mem[0]  <= '0;
         buf_mem[1]  <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
      end else begin
         cap_pending <= ren;
         if (push) begin
            buf_mem[wr_ptr] <= mem_data;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Bench for dpram_stream_reader: a behavioural RAM plus a queue-based model of
// the expected word stream, address sequence and handshake rules.
module tb_dpram_stream_reader;

   logic       clk = 1'b0;
   logic       RN = 1'b0;
   logic       start = 1'b0;
   logic [6:0] start_addr = '0;
   logic [7:0] len = '0;
   logic       busy;
   logic       done;
   logic       ren;
   logic [6:0] raddr;
   logic [7:0] mem_data = '0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;

   logic [7:0] ram [128];
   int nchecks = 0;
   int nerrors = 0;

   dpram_stream_reader #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
      .clk(clk), .RN(RN), .start(start), .start_addr(start_addr), .len(len),
      .busy(busy), .done(done), .ren(ren), .raddr(raddr), .mem_data(mem_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (ren) mem_data <= ram[raddr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic pick_ready(input int mode, input int cyc);
      logic [15:0] pat;
      pat = 16'b0110_1011_0010_1001;
      if (mode == 0) return 1'b1;
      if (mode == 1) return pat[cyc % 16];
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic burst(input int addr, input int n, input int mode, input bit restart);
      logic [7:0] q[$];
      int  issued = 0;
      int  accepted = 0;
      int  cyc = 0;
      int  last_acc = -10;
      bit  seen_valid = 0;
      bit  hold = 0;
      bit  fin = 0;
      logic [7:0] held = '0;
      for (int k = 0; k < n; k++) q.push_back(ram[(addr + k) % 128]);
      @(negedge clk);
      start      = 1'b1;
      start_addr = 7'(addr);
      len        = 8'(n);
      out_ready  = pick_ready(mode, 0);
      while (!fin) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (restart && cyc == 4) begin
            start      = 1'b1;
            start_addr = 7'(addr + 50);
            len        = 8'd3;
         end
         if (restart && cyc == 5) start = 1'b0;
         if (cyc == 1) chk("first_ren", 32'(ren), 32'd1);
         if (ren) begin
            chk("raddr", 32'(raddr), 32'((addr + issued) % 128));
            issued++;
         end
         chk("credit_le_2", 32'((issued - accepted) <= 2), 32'd1);
         chk("issued_le_len", 32'(issued <= n), 32'd1);
         if (hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(held));
         end
         if (out_valid && !seen_valid) begin
            seen_valid = 1;
            chk("first_valid_cyc", 32'(cyc), 32'd3);
         end
         if (done) begin
            chk("done_after_last", 32'(cyc), 32'(last_acc + 1));
            chk("words_at_done", 32'(accepted), 32'(n));
            chk("busy_at_done", 32'(busy), 32'd0);
            fin = 1;
         end else begin
            chk("busy_during", 32'(busy), 32'd1);
         end
         out_ready = pick_ready(mode, cyc);
         if (!fin && out_valid && out_ready) begin
            if (q.size() == 0) chk("extra_word", 32'd1, 32'd0);
            else chk("word", 32'(out_data), 32'(q.pop_front()));
            accepted++;
            last_acc = cyc;
         end
         hold = out_valid && !out_ready;
         held = out_data;
         if (!fin && cyc > 3000) begin
            chk("timeout", 32'd0, 32'd1);
            fin = 1;
         end
      end
      @(negedge clk);
      chk("done_single", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ren", 32'(ren), 32'd0);
   endtask

   initial begin
      int acc;
      for (int i = 0; i < 128; i++) ram[i] = 8'(i + 'h10);

      repeat (3) @(negedge clk);
      chk("rst_state", {27'd0, busy, done, ren, out_valid, 1'b0}, 32'd0);
      chk("rst_raddr", 32'(raddr), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      RN = 1'b1;
      @(negedge clk);

      burst(5, 4, 0, 0);
      burst(126, 4, 0, 0);
      burst(3, 8, 1, 0);

      @(negedge clk);
      start = 1'b1;
      len   = 8'd0;
      start_addr = 7'd9;
      @(negedge clk);
      start = 1'b0;
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_ren", 32'(ren), 32'd0);
      @(negedge clk);
      chk("zero_done_clear", 32'(done), 32'd0);
      chk("zero_ren2", 32'(ren), 32'd0);
      chk("zero_busy2", 32'(busy), 32'd0);

      burst(40, 10, 2, 1);

      @(negedge clk);
      start = 1'b1;
      start_addr = 7'd20;
      len = 8'd10;
      out_ready = 1'b1;
      acc = 0;
      for (int c = 0; c < 100 && acc < 3; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (out_valid && out_ready) acc++;
      end
      chk("pre_rst_words", 32'(acc), 32'd3);
      @(negedge clk);
      RN = 1'b0;
      #1;
      chk("midrst_state", {28'd0, busy, done, ren, out_valid}, 32'd0);
      chk("midrst_raddr", 32'(raddr), 32'd0);
      @(negedge clk);
      RN = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         chk("post_rst_quiet", {28'd0, busy, done, ren, out_valid}, 32'd0);
      end
      burst(0, 2, 0, 0);

      burst(0, 255, 0, 0);

      for (int i = 0; i < 128; i++) ram[i] = 8'($urandom);
      for (int t = 0; t < 6; t++)
         burst(int'($urandom_range(0, 127)), int'($urandom_range(1, 40)), 2, 0);
      burst(int'($urandom_range(0, 127)), 200, 2, 0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
